// File: rtl/fwd_hazard_unit_if.sv
// Bundles the pipeline-side signals of the forwarding/hazard unit.
// The master drives the pipeline state, and the unit answers as the slave.
interface fwd_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int N_SRC  = 2,
    parameter int CNT_W  = 16
);
    logic                      flush_i;
    logic [N_SRC*REG_AW-1:0]   id_src_i;
    logic [N_SRC-1:0]          id_src_used_i;
    logic [N_SRC*REG_AW-1:0]   ex_src_i;
    logic [REG_AW-1:0]         ex_rd_i;
    logic                      ex_regwrite_i;
    logic                      ex_memread_i;
    logic [REG_AW-1:0]         mem_rd_i;
    logic                      mem_regwrite_i;
    logic [REG_AW-1:0]         wb_rd_i;
    logic                      wb_regwrite_i;
    logic [2*N_SRC-1:0]        forward_o;
    logic                      stall_o;
    logic [CNT_W-1:0]          stall_cnt_o;

    modport master (
        output flush_i, id_src_i, id_src_used_i, ex_src_i, ex_rd_i, ex_regwrite_i,
               ex_memread_i, mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i,
        input  forward_o, stall_o, stall_cnt_o
    );

    modport slave (
        input  flush_i, id_src_i, id_src_used_i, ex_src_i, ex_rd_i, ex_regwrite_i,
               ex_memread_i, mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i,
        output forward_o, stall_o, stall_cnt_o
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use/RAW stall control for the 5-stage pipeline,
// with a saturating count of stall cycles.
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int N_SRC    = 2,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fwd_hazard_unit_if.slave   bus
);

    localparam logic [0:0]        ST_IDLE   = 1'b0;
    localparam logic [0:0]        ST_HOLD   = 1'b1;
    localparam logic [3:0]        HOLD_INIT = 4'(LOAD_LAT - 1);
    localparam logic              FWD_ON    = (FWD_EN != 32'sd0);
    localparam logic              LAT_GT1   = (LOAD_LAT > 32'sd1);
    localparam logic [REG_AW-1:0] REG_ZERO  = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [2*N_SRC-1:0] forward_s;
    logic [N_SRC-1:0]   ex_hit_s;
    logic [N_SRC-1:0]   mem_hit_s;
    logic               lu_s;
    logic               raw_s;
    logic               stall_s;
    logic [0:0]         state_q, state_d;
    logic [3:0]         hold_q, hold_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    // EX-stage operand source select; MEM is checked first so it wins over WB.
    always_comb begin
        forward_s = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!FWD_ON) begin
                forward_s[2*k +: 2] = 2'b00;
            end else if (bus.mem_regwrite_i && (bus.mem_rd_i != REG_ZERO) &&
                         (bus.mem_rd_i == bus.ex_src_i[k*REG_AW +: REG_AW])) begin
                forward_s[2*k +: 2] = 2'b01;
            end else if (bus.wb_regwrite_i && (bus.wb_rd_i != REG_ZERO) &&
                         (bus.wb_rd_i == bus.ex_src_i[k*REG_AW +: REG_AW])) begin
                forward_s[2*k +: 2] = 2'b10;
            end else begin
                forward_s[2*k +: 2] = 2'b00;
            end
        end
    end

    // Hazard detection: per-channel producer matches against used ID sources.
    always_comb begin
        ex_hit_s  = '0;
        mem_hit_s = '0;
        for (int k = 0; k < N_SRC; k++) begin
            ex_hit_s[k]  = bus.id_src_used_i[k] && bus.ex_regwrite_i &&
                           (bus.ex_rd_i != REG_ZERO) &&
                           (bus.id_src_i[k*REG_AW +: REG_AW] == bus.ex_rd_i);
            mem_hit_s[k] = bus.id_src_used_i[k] && bus.mem_regwrite_i &&
                           (bus.mem_rd_i != REG_ZERO) &&
                           (bus.id_src_i[k*REG_AW +: REG_AW] == bus.mem_rd_i);
        end
        // WB is never a hazard: the register file writes in the first half-cycle.
        lu_s  = FWD_ON && bus.ex_memread_i && (|ex_hit_s);
        raw_s = !FWD_ON && ((|ex_hit_s) || (|mem_hit_s));
    end

    // Stall FSM next state, hold countdown and stall-counter update; flush overrides all.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stall_s = 1'b0;
        if (bus.flush_i) begin
            state_d = ST_IDLE;
            hold_d  = 4'd0;
            stall_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    stall_s = lu_s || raw_s;
                    if (lu_s && LAT_GT1) begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_INIT;
                    end else begin
                        state_d = ST_IDLE;
                        hold_d  = 4'd0;
                    end
                end
                ST_HOLD: begin
                    stall_s = 1'b1;
                    if (hold_q <= 4'd1) begin
                        state_d = ST_IDLE;
                        hold_d  = 4'd0;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = hold_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hold_d  = 4'd0;
                    stall_s = 1'b0;
                end
            endcase
        end
        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, hold counter and stall counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            hold_q      <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.forward_o   = forward_s;
    assign bus.stall_o     = stall_s;
    assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Drives four differently-configured units with one shared stimulus stream and
// compares each against a cycle-level reference model of the forwarding and stall rules.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [9:0] id_src, ex_src;
    logic [1:0] id_used;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       ex_rw, ex_mr, mem_rw, wb_rw;

    always #5 clk = ~clk;

    // Configs: A fwd/lat1, B fwd/lat3, C no-fwd/lat1, D fwd/lat3 with a 2-bit counter
    fwd_hazard_unit_if #(.REG_AW(5), .N_SRC(2), .CNT_W(16)) ifa ();
    fwd_hazard_unit_if #(.REG_AW(5), .N_SRC(2), .CNT_W(16)) ifb ();
    fwd_hazard_unit_if #(.REG_AW(5), .N_SRC(2), .CNT_W(16)) ifc ();
    fwd_hazard_unit_if #(.REG_AW(5), .N_SRC(2), .CNT_W(2))  ifd ();

    fwd_hazard_unit #(.REG_AW(5), .N_SRC(2), .LOAD_LAT(1), .FWD_EN(1), .CNT_W(16))
        dut_a (.clk_i(clk), .rst_i(rst_n), .bus(ifa.slave));
    fwd_hazard_unit #(.REG_AW(5), .N_SRC(2), .LOAD_LAT(3), .FWD_EN(1), .CNT_W(16))
        dut_b (.clk_i(clk), .rst_i(rst_n), .bus(ifb.slave));
    fwd_hazard_unit #(.REG_AW(5), .N_SRC(2), .LOAD_LAT(1), .FWD_EN(0), .CNT_W(16))
        dut_c (.clk_i(clk), .rst_i(rst_n), .bus(ifc.slave));
    fwd_hazard_unit #(.REG_AW(5), .N_SRC(2), .LOAD_LAT(3), .FWD_EN(1), .CNT_W(2))
        dut_d (.clk_i(clk), .rst_i(rst_n), .bus(ifd.slave));

    assign ifa.flush_i = flush;   assign ifa.id_src_i = id_src;   assign ifa.id_src_used_i = id_used;
    assign ifa.ex_src_i = ex_src; assign ifa.ex_rd_i = ex_rd;     assign ifa.ex_regwrite_i = ex_rw;
    assign ifa.ex_memread_i = ex_mr; assign ifa.mem_rd_i = mem_rd; assign ifa.mem_regwrite_i = mem_rw;
    assign ifa.wb_rd_i = wb_rd;   assign ifa.wb_regwrite_i = wb_rw;
    assign ifb.flush_i = flush;   assign ifb.id_src_i = id_src;   assign ifb.id_src_used_i = id_used;
    assign ifb.ex_src_i = ex_src; assign ifb.ex_rd_i = ex_rd;     assign ifb.ex_regwrite_i = ex_rw;
    assign ifb.ex_memread_i = ex_mr; assign ifb.mem_rd_i = mem_rd; assign ifb.mem_regwrite_i = mem_rw;
    assign ifb.wb_rd_i = wb_rd;   assign ifb.wb_regwrite_i = wb_rw;
    assign ifc.flush_i = flush;   assign ifc.id_src_i = id_src;   assign ifc.id_src_used_i = id_used;
    assign ifc.ex_src_i = ex_src; assign ifc.ex_rd_i = ex_rd;     assign ifc.ex_regwrite_i = ex_rw;
    assign ifc.ex_memread_i = ex_mr; assign ifc.mem_rd_i = mem_rd; assign ifc.mem_regwrite_i = mem_rw;
    assign ifc.wb_rd_i = wb_rd;   assign ifc.wb_regwrite_i = wb_rw;
    assign ifd.flush_i = flush;   assign ifd.id_src_i = id_src;   assign ifd.id_src_used_i = id_used;
    assign ifd.ex_src_i = ex_src; assign ifd.ex_rd_i = ex_rd;     assign ifd.ex_regwrite_i = ex_rw;
    assign ifd.ex_memread_i = ex_mr; assign ifd.mem_rd_i = mem_rd; assign ifd.mem_regwrite_i = mem_rw;
    assign ifd.wb_rd_i = wb_rd;   assign ifd.wb_regwrite_i = wb_rw;

    logic [3:0]  obs_fwd [4];
    logic        obs_stall [4];
    logic [15:0] obs_cnt [4];
    assign obs_fwd[0] = ifa.forward_o; assign obs_stall[0] = ifa.stall_o; assign obs_cnt[0] = ifa.stall_cnt_o;
    assign obs_fwd[1] = ifb.forward_o; assign obs_stall[1] = ifb.stall_o; assign obs_cnt[1] = ifb.stall_cnt_o;
    assign obs_fwd[2] = ifc.forward_o; assign obs_stall[2] = ifc.stall_o; assign obs_cnt[2] = ifc.stall_cnt_o;
    assign obs_fwd[3] = ifd.forward_o; assign obs_stall[3] = ifd.stall_o; assign obs_cnt[3] = {14'd0, ifd.stall_cnt_o};

    // Reference model: rem = stall cycles still owed after the current one.
    int          cfg_fwd [4] = '{1, 1, 0, 1};
    int          cfg_lat [4] = '{1, 3, 1, 3};
    int          cfg_max [4] = '{65535, 65535, 65535, 3};
    int          rem [4];
    int          nrem [4];
    int          cnt [4];
    logic        exp_stall [4];
    logic [3:0]  exp_fwd [4];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [1:0] fsel(input int k);
        logic [4:0] s;
        s = ex_src[k*5 +: 5];
        if (mem_rw && mem_rd != 5'd0 && mem_rd == s) return 2'b01;
        if (wb_rw && wb_rd != 5'd0 && wb_rd == s) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_eval();
        bit ex_hit, mem_hit, lu, raw;
        logic [4:0] s;
        ex_hit = 1'b0;
        mem_hit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s = id_src[k*5 +: 5];
            if (id_used[k] && ex_rw && ex_rd != 5'd0 && s == ex_rd) ex_hit = 1'b1;
            if (id_used[k] && mem_rw && mem_rd != 5'd0 && s == mem_rd) mem_hit = 1'b1;
        end
        for (int d = 0; d < 4; d++) begin
            lu  = (cfg_fwd[d] != 0) && ex_mr && ex_hit;
            raw = (cfg_fwd[d] == 0) && (ex_hit || mem_hit);
            exp_fwd[d] = (cfg_fwd[d] != 0) ? {fsel(1), fsel(0)} : 4'b0000;
            if (flush) begin
                exp_stall[d] = 1'b0; nrem[d] = 0;
            end else if (rem[d] > 0) begin
                exp_stall[d] = 1'b1; nrem[d] = rem[d] - 1;
            end else begin
                exp_stall[d] = lu || raw; nrem[d] = lu ? cfg_lat[d] - 1 : 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
        for (int d = 0; d < 4; d++) begin
            check($sformatf("fwd[%0d]", d), {28'd0, obs_fwd[d]}, {28'd0, exp_fwd[d]});
            check($sformatf("stall[%0d]", d), {31'd0, obs_stall[d]}, {31'd0, exp_stall[d]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 4; d++) begin
            rem[d] = nrem[d];
            if (exp_stall[d] && cnt[d] < cfg_max[d]) cnt[d]++;
        end
        #1;
        for (int d = 0; d < 4; d++) check($sformatf("cnt[%0d]", d), {16'd0, obs_cnt[d]}, cnt[d]);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic clear_inputs();
        flush = 1'b0; id_src = 10'd0; id_used = 2'b00; ex_src = 10'd0;
        ex_rd = 5'd0; ex_rw = 1'b0; ex_mr = 1'b0;
        mem_rd = 5'd0; mem_rw = 1'b0; wb_rd = 5'd0; wb_rw = 1'b0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin rem[d] = 0; cnt[d] = 0; end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        settle();
        for (int d = 0; d < 4; d++) check($sformatf("rst_cnt[%0d]", d), {16'd0, obs_cnt[d]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic load_use(input logic [1:0] used);
        clear_inputs();
        ex_mr = 1'b1; ex_rw = 1'b1; ex_rd = 5'd8;
        id_src = {5'd8, 5'd3}; id_used = used;
    endtask

    initial begin
        model_reset();
        clear_inputs();
        rst_n = 1'b0;
        #12;
        do_reset();

        // Forwarding priority
        ex_src = {5'd5, 5'd5}; mem_rd = 5'd5; mem_rw = 1'b1; wb_rd = 5'd5; wb_rw = 1'b1;
        settle(); check("fwd_mem_wins", {28'd0, obs_fwd[0]}, 32'b0101);
        check("fwd_off_c", {28'd0, obs_fwd[2]}, 32'd0);
        tick();
        mem_rw = 1'b0;
        settle(); check("fwd_wb", {28'd0, obs_fwd[0]}, 32'b1010);
        tick();
        mem_rd = 5'd0; mem_rw = 1'b1;
        settle(); check("fwd_mem_r0", {28'd0, obs_fwd[0]}, 32'b1010);
        tick();

        // Load-use, single pulse: A stalls 1 cycle, B stalls 3
        do_reset();
        load_use(2'b10);
        settle(); check("lu_a_stall", {31'd0, obs_stall[0]}, 32'd1);
        check("lu_b_stall1", {31'd0, obs_stall[1]}, 32'd1);
        tick(); check("lu_a_cnt", {16'd0, obs_cnt[0]}, 32'd1);
        clear_inputs();
        settle(); check("lu_a_bubble", {31'd0, obs_stall[0]}, 32'd0);
        check("lu_b_stall2", {31'd0, obs_stall[1]}, 32'd1);
        tick();
        settle(); check("lu_b_stall3", {31'd0, obs_stall[1]}, 32'd1);
        tick();
        settle(); check("lu_b_done", {31'd0, obs_stall[1]}, 32'd0);
        tick(); check("lu_b_cnt", {16'd0, obs_cnt[1]}, 32'd3);

        // Unused source never stalls
        do_reset();
        load_use(2'b00);
        settle(); check("lu_unused", {31'd0, obs_stall[0]}, 32'd0);
        tick();

        // Flush during HOLD
        do_reset();
        load_use(2'b10);
        step();
        clear_inputs(); flush = 1'b1;
        settle(); check("flush_b_stall", {31'd0, obs_stall[1]}, 32'd0);
        tick();
        flush = 1'b0;
        settle(); check("flush_b_idle", {31'd0, obs_stall[1]}, 32'd0);
        tick(); check("flush_b_cnt", {16'd0, obs_cnt[1]}, 32'd1);

        // No-forward mode: EX and MEM producers stall, WB does not
        do_reset();
        ex_src = {5'd4, 5'd4}; id_src = {5'd0, 5'd4}; id_used = 2'b01;
        ex_rd = 5'd4; ex_rw = 1'b1;
        settle(); check("nf_ex_stall", {31'd0, obs_stall[2]}, 32'd1);
        tick();
        ex_rd = 5'd0; ex_rw = 1'b0; mem_rd = 5'd4; mem_rw = 1'b1;
        settle(); check("nf_mem_stall", {31'd0, obs_stall[2]}, 32'd1);
        check("nf_fwd_zero", {28'd0, obs_fwd[2]}, 32'd0);
        tick();
        mem_rd = 5'd0; mem_rw = 1'b0; wb_rd = 5'd4; wb_rw = 1'b1;
        settle(); check("nf_wb_nostall", {31'd0, obs_stall[2]}, 32'd0);
        tick(); check("nf_cnt", {16'd0, obs_cnt[2]}, 32'd2);

        // Saturation on the 2-bit counter
        do_reset();
        load_use(2'b10);
        for (int i = 0; i < 6; i++) step();
        check("sat_d_cnt", {16'd0, obs_cnt[3]}, 32'd3);

        // Asynchronous reset in the middle of HOLD
        do_reset();
        load_use(2'b10);
        step();
        clear_inputs();
        settle(); check("hold_d_stall", {31'd0, obs_stall[3]}, 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_d_stall", {31'd0, obs_stall[3]}, 32'd0);
        check("arst_d_cnt", {16'd0, obs_cnt[3]}, 32'd0);
        check("arst_b_stall", {31'd0, obs_stall[1]}, 32'd0);
        settle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            flush   = ($urandom_range(0, 15) == 0);
            id_src  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            ex_src  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            id_used = 2'($urandom_range(0, 3));
            ex_rd   = 5'($urandom_range(0, 3));
            mem_rd  = 5'($urandom_range(0, 3));
            wb_rd   = 5'($urandom_range(0, 3));
            ex_rw   = 1'($urandom_range(0, 1));
            ex_mr   = ($urandom_range(0, 2) == 0);
            mem_rw  = 1'($urandom_range(0, 1));
            wb_rw   = 1'($urandom_range(0, 1));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the 5-stage pipelined CPU.
- Resolves EX-stage operand sources for N_SRC channels, with MEM-over-WB priority.
- Detects load-use hazards at ID and holds the front end for a configurable number of cycles through a stall FSM.
- Also supports a no-forwarding mode, where every RAW hazard stalls, and keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- REG_AW, 5, register address width.
- N_SRC, 2, number of source-operand channels (ch0=rs, ch1=rt, ...).
- LOAD_LAT, 1, stall cycles per load-use hazard (legal range 1..15).
- FWD_EN, 1, 1 = forwarding enabled; 0 = no forwarding, stall on any RAW.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  taken branch/jump; aborts stall sequence.
- id_src_i  in  N_SRC*REG_AW  ID-stage source regs, ch k at [k*REG_AW +: REG_AW].
- id_src_used_i  in  N_SRC  per-channel "source actually read" qualifier.
- ex_src_i  in  N_SRC*REG_AW  EX-stage source regs.
- ex_rd_i  in  REG_AW  EX destination.
- ex_regwrite_i  in  1  EX instruction writes a register.
- ex_memread_i  in  1  EX instruction is a load.
- mem_rd_i  in  REG_AW  MEM destination.
- mem_regwrite_i  in  1  MEM instruction writes a register.
- wb_rd_i  in  REG_AW  WB destination.
- wb_regwrite_i  in  1  WB instruction writes a register.
- forward_o  out  2*N_SRC  per-channel select: 00 regfile, 01 MEM, 10 WB.
- stall_o  out  1  hold PC and IF/ID, insert bubble into ID/EX.
- stall_cnt_o  out  CNT_W  total stall cycles, saturating.

Behaviour:
- Reset (rst_i=0, asynchronous): FSM=IDLE, hold counter=0, stall_cnt_o=0. Combinational outputs follow inputs; stall_o=0 in HOLD-free state unless a hazard is present.
- Forwarding (combinational, per channel k, FWD_EN=1):
  - MEM match: mem_regwrite_i & mem_rd_i!=0 & mem_rd_i==ex_src[k] -> 01.
  - Else WB match: wb_regwrite_i & wb_rd_i!=0 & wb_rd_i==ex_src[k] -> 10.
  - Else 00.
  - MEM always wins when both match.
- FWD_EN=0: forward_o is constantly 0.
- Hazard term lu (FWD_EN=1): ex_memread_i & ex_regwrite_i & ex_rd_i!=0 & any k with id_src_used_i[k] & id_src[k]==ex_rd_i.
- Hazard term raw (FWD_EN=0): any used ID source equals a non-zero ex_rd_i with ex_regwrite_i, or a non-zero mem_rd_i with mem_regwrite_i. WB is not a hazard; the regfile writes first half-cycle.
- FSM states IDLE and HOLD; hold counter is 4 bits.
- IDLE:
  - stall_o = lu|raw (combinational, same cycle).
  - If lu & ~flush_i & LOAD_LAT>1: go to HOLD, counter = LOAD_LAT-1.
  - raw never enters HOLD; it re-evaluates each cycle as the pipeline drains.
- HOLD:
  - stall_o=1 regardless of hazard inputs.
  - Counter decrements each cycle; return to IDLE in the cycle after the counter reaches 1.
  - A lu hazard of LOAD_LAT=N therefore gives exactly N consecutive stall cycles.
- flush_i: forces stall_o=0 that cycle and next state IDLE. Flush beats both a hazard and HOLD.
- stall_cnt_o: increments by 1 on every clock edge where stall_o=1. It saturates at all-ones and never wraps.
- Reset mid-HOLD: immediate return to IDLE and stall_o deasserts asynchronously. Count clears.
- Register 0 never forwards and never stalls.

Test Plan:
- Forwarding priority: FWD_EN=1, ex_src ch0=ch1=5, mem_rd=5/regwrite=1, wb_rd=5/regwrite=1 -> forward_o=0101. Drop mem_regwrite -> forward_o=1010. Set mem_rd=0 with regwrite -> WB still chosen.
- Load-use, LOAD_LAT=1: ex_memread=1, ex_regwrite=1, ex_rd=8, id ch1=8 used -> stall_o=1 for exactly 1 cycle. Next cycle, with the bubble (ex_memread=0), stall_o=0 and stall_cnt_o=1. Same stimulus with id_src_used[1]=0 -> no stall.
- LOAD_LAT=3: single lu pulse -> stall_o high 3 consecutive cycles, then 0; stall_cnt_o=3. Assert flush_i in 2nd cycle -> stall_o=0 that cycle, FSM IDLE, stall_cnt_o=1.
- No-forward mode, FWD_EN=0: ex_rd=4 regwrite, id ch0=4 -> stall. Next cycle mem_rd=4 -> stall. Then wb_rd=4 -> no stall. forward_o=0 throughout; stall_cnt_o=2.
- Saturation/reset: CNT_W=2, hold a hazard for 6 cycles -> stall_cnt_o stops at 3. Drive rst_i low mid-HOLD -> stall_o and stall_cnt_o go to 0 without a clock edge.
